dpram_stream_reader: RTL

Read-side sequencer for any `dpram_wrapper` instance: ifm, filter, affine, psum row and maxpool buffers. It sits directly downstream of the buffer's port B. It drives `enb`/`addrb`, absorbs the fixed N_DELAY read latency, and presents the words as a valid/ready stream to the compute stage. A small credit-controlled skid FIFO lets the stream run at one word per cycle under continuous `m_ready` without ever dropping a word under backpressure.

---
 rtl/dpram_stream_reader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dpram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_stream_reader
//  Description : Read-side sequencer for a dpram_wrapper port B. Issues
//                consecutive reads, absorbs the fixed N_DELAY read latency
//                and presents the returned words as a valid/ready stream
//                through a credit-controlled skid FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_stream_reader #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   num_words,
    output logic          busy,
    output logic          done,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] dob,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    // Skid FIFO must cover every read that can be in flight plus the head
    // word and one word of slack so the stream never bubbles.
    localparam int FIFO_DEPTH = N_DELAY + 2;
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;        // next address to issue
    logic [AW-1:0]       addrb_q, addrb_d;      // last issued address (held)
    logic [AW:0]         remaining_q, remaining_d;
    logic [N_DELAY-1:0]  tag_q;                 // one bit per pipeline stage
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]       fifo_mem_q [FIFO_DEPTH];

    logic issue;
    logic push;
    logic pop;
    logic credit_ok;

    // Issue decision, FIFO handshakes and occupancy bookkeeping.
    always_comb begin
        push       = tag_q[N_DELAY-1];
        pop        = (fifo_cnt_q != '0) && m_ready;
        // Credit counts reads still in the pipe as already occupying the FIFO.
        credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
        issue      = (state_q == S_RUN) && (remaining_q != '0) && credit_ok;
        inflight_d = inflight_q + CW'(issue) - CW'(push);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    // Next-state logic and job address/length tracking.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        addrb_d     = addrb_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = num_words;
                    state_d     = (num_words == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    addrb_d     = addr_q;
                    addr_d      = addr_q + AW'(1);
                    remaining_d = remaining_q - (AW + 1)'(1);
                    if (remaining_q == (AW + 1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Look at next-cycle occupancy so done lands right after the
                // final handshake rather than one cycle later.
                if ((inflight_d == '0) && (fifo_cnt_d == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign enb     = busy;
    assign done    = (state_q == S_DONE);
    assign addrb   = issue ? addr_q : addrb_q;
    assign m_valid = (fifo_cnt_q != '0);
    assign m_data  = fifo_mem_q[rd_ptr_q];

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            addrb_q     <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            addrb_q     <= addrb_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Issue tags track the RAM pipeline; the last stage marks a valid dob.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= issue;
            for (int i = 1; i < N_DELAY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Skid FIFO storage, cleared on reset so the idle head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= dob;
        end
    end

endmodule
`default_nettype wire
